// File: rtl/reu_pkg.sv
// Shared encodings for the REU transfer engine: command codes, FSM states and
// the per-byte entry state for each command.
package reu_pkg;

    typedef enum logic [1:0] {
        CmdStash  = 2'd0,
        CmdFetch  = 2'd1,
        CmdSwap   = 2'd2,
        CmdVerify = 2'd3
    } cmd_e;

    typedef enum logic [3:0] {
        StSync,
        StIdle,
        StC64Rd,
        StC64Wr,
        StRamRd,
        StRamWr,
        StCmp,
        StNext,
        StFinish
    } state_e;

    // STASH and VERIFY start each byte on the C64 side, FETCH and SWAP on the RAM side.
    function automatic state_e first_state(cmd_e c);
        return (c == CmdStash || c == CmdVerify) ? StC64Rd : StRamRd;
    endfunction

endpackage

// File: rtl/reu_dma_engine_if.sv
// Bus bundle between the REU engine, the C64 DMA toggle port and the
// expansion-RAM controller.
interface reu_dma_engine_if #(
    parameter int unsigned RAM_AW = 24
);
    logic [15:0]       dma_a;
    logic [7:0]        dma_d;
    logic              dma_rw;
    logic              dma_req;
    logic              dma_ack;
    logic [7:0]        dma_q;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic              ram_req;
    logic              ram_ack;
    logic [7:0]        ram_rdata;

    modport master (
        output dma_a, dma_d, dma_rw, dma_req, ram_addr, ram_wdata, ram_we, ram_req,
        input  dma_ack, dma_q, ram_ack, ram_rdata
    );

    modport slave (
        input  dma_a, dma_d, dma_rw, dma_req, ram_addr, ram_wdata, ram_we, ram_req,
        output dma_ack, dma_q, ram_ack, ram_rdata
    );
endinterface

// File: rtl/dma_toggle_port.sv
// Request side of the C64 DMA toggle handshake: owns dma_req, detects completion
// and latches the read byte.
module dma_toggle_port (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic       start,
    input  logic       dma_ack,
    input  logic [7:0] dma_q,
    output logic       dma_req,
    output logic       complete,
    output logic [7:0] q
);
    logic       req_q;
    logic       pend_q;
    logic [7:0] q_q;

    assign complete = pend_q && (dma_ack == req_q);
    assign dma_req  = req_q;
    assign q        = q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q  <= 1'b0;
            pend_q <= 1'b0;
            q_q    <= 8'h00;
        end else begin
            // Re-align after reset so a cycle still in flight on the bus is not
            // mistaken for a fresh request.
            if (sync) begin
                req_q  <= dma_ack;
                pend_q <= 1'b0;
            end else if (start) begin
                req_q  <= ~req_q;
                pend_q <= 1'b1;
            end else if (complete) begin
                pend_q <= 1'b0;
            end
            if (complete) q_q <= dma_q;
        end
    end
endmodule

// File: rtl/reu_dma_engine.sv
// REU transfer engine: sequences STASH/FETCH/SWAP/VERIFY byte by byte over the
// C64 DMA port and the expansion-RAM port.
module reu_dma_engine
    import reu_pkg::*;
#(
    parameter int unsigned RAM_AW = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [1:0]        cmd,
    input  logic [15:0]       cmd_c64_addr,
    input  logic [RAM_AW-1:0] cmd_reu_addr,
    input  logic [15:0]       cmd_len,
    input  logic              fix_c64,
    input  logic              fix_reu,
    reu_dma_engine_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              verify_err,
    output logic [15:0]       cur_c64_addr,
    output logic [RAM_AW-1:0] cur_reu_addr,
    output logic [15:0]       cur_len
);
    state_e            state_q, state_d;
    cmd_e              cmd_q;
    logic              fix_c64_q, fix_reu_q, stop_q, busy_q, done_q, verr_q;
    logic [15:0]       c64_q, c64_d, len_q, len_d;
    logic [RAM_AW-1:0] reu_q, reu_d;
    logic [7:0]        ram_byte_q, c64_byte;
    logic [15:0]       dma_a_q;
    logic [7:0]        dma_d_q;
    logic              dma_rw_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [7:0]        ram_wdata_q;
    logic              ram_we_q, ram_req_q;
    logic              sync, accept, complete, enter_c64, enter_ram;

    dma_toggle_port u_toggle (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .start    (enter_c64),
        .dma_ack  (bus.dma_ack),
        .dma_q    (bus.dma_q),
        .dma_req  (bus.dma_req),
        .complete (complete),
        .q        (c64_byte)
    );

    always_comb begin
        state_d = state_q;
        sync    = 1'b0;
        accept  = 1'b0;
        c64_d   = c64_q;
        reu_d   = reu_q;
        len_d   = len_q;
        unique case (state_q)
            StSync: begin
                sync    = 1'b1;
                state_d = StIdle;
            end
            StIdle: begin
                if (cmd_start) begin
                    accept  = 1'b1;
                    state_d = first_state(cmd_e'(cmd));
                    c64_d   = cmd_c64_addr;
                    reu_d   = cmd_reu_addr;
                    len_d   = cmd_len;
                end
            end
            StC64Rd: if (complete) state_d = (cmd_q == CmdVerify) ? StRamRd : StRamWr;
            StC64Wr: if (complete) state_d = StNext;
            StRamRd: begin
                if (bus.ram_ack) begin
                    state_d = (cmd_q == CmdFetch) ? StC64Wr :
                              (cmd_q == CmdSwap)  ? StC64Rd : StCmp;
                end
            end
            StRamWr: if (bus.ram_ack) state_d = (cmd_q == CmdSwap) ? StC64Wr : StNext;
            StCmp:   state_d = StNext;
            StNext: begin
                if (!fix_c64_q) c64_d = c64_q + 16'd1;
                if (!fix_reu_q) reu_d = reu_q + RAM_AW'(1);
                // A length of 0 wraps to 65535 here, giving a 65536-byte transfer.
                if (len_q != 16'd1) len_d = len_q - 16'd1;
                state_d = (len_q == 16'd1 || stop_q) ? StFinish : first_state(cmd_q);
            end
            StFinish: state_d = StIdle;
            default:  state_d = StSync;
        endcase
    end

    assign enter_c64 = (state_d == StC64Rd || state_d == StC64Wr) && (state_d != state_q);
    assign enter_ram = (state_d == StRamRd || state_d == StRamWr) && (state_d != state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSync;
            cmd_q       <= CmdStash;
            fix_c64_q   <= 1'b0;
            fix_reu_q   <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            verr_q      <= 1'b0;
            c64_q       <= '0;
            reu_q       <= '0;
            len_q       <= '0;
            ram_byte_q  <= '0;
            dma_a_q     <= '0;
            dma_d_q     <= '0;
            dma_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c64_q   <= c64_d;
            reu_q   <= reu_d;
            len_q   <= len_d;
            done_q  <= (state_d == StFinish);
            if (accept) begin
                cmd_q     <= cmd_e'(cmd);
                fix_c64_q <= fix_c64;
                fix_reu_q <= fix_reu;
                busy_q    <= 1'b1;
                verr_q    <= 1'b0;
                stop_q    <= 1'b0;
            end
            if (state_d == StFinish) busy_q <= 1'b0;
            if (state_q == StCmp && c64_byte != ram_byte_q) begin
                verr_q <= 1'b1;
                stop_q <= 1'b1;
            end
            // FETCH writes the byte arriving this cycle; SWAP writes the one held from RAM_RD.
            if (enter_c64) begin
                dma_a_q  <= c64_d;
                dma_rw_q <= (state_d == StC64Wr);
                dma_d_q  <= (state_q == StRamRd) ? bus.ram_rdata : ram_byte_q;
            end
            // RAM writes are always entered from a completing C64 read.
            if (enter_ram) begin
                ram_addr_q  <= reu_d;
                ram_we_q    <= (state_d == StRamWr);
                ram_wdata_q <= bus.dma_q;
                ram_req_q   <= 1'b1;
            end else if ((state_q == StRamRd || state_q == StRamWr) && bus.ram_ack) begin
                ram_req_q <= 1'b0;
            end
            if (state_q == StRamRd && bus.ram_ack) ram_byte_q <= bus.ram_rdata;
        end
    end

    assign bus.dma_a     = dma_a_q;
    assign bus.dma_d     = dma_d_q;
    assign bus.dma_rw    = dma_rw_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_req   = ram_req_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign verify_err    = verr_q;
    assign cur_c64_addr  = c64_q;
    assign cur_reu_addr  = reu_q;
    assign cur_len       = len_q;
endmodule

// File: tb/tb_reu_dma_engine.sv
// Scoreboard bench for reu_dma_engine with behavioural C64 bus and RAM models.
module tb_reu_dma_engine;
    import reu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_start = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic [15:0] cmd_c64_addr = '0, cmd_len = '0;
    logic [23:0] cmd_reu_addr = '0;
    logic        fix_c64 = 1'b0, fix_reu = 1'b0;
    logic        busy, done, verify_err;
    logic [15:0] cur_c64_addr, cur_len;
    logic [23:0] cur_reu_addr;

    reu_dma_engine_if #(.RAM_AW(24)) bus ();

    reu_dma_engine #(.RAM_AW(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_start    (cmd_start),
        .cmd          (cmd),
        .cmd_c64_addr (cmd_c64_addr),
        .cmd_reu_addr (cmd_reu_addr),
        .cmd_len      (cmd_len),
        .fix_c64      (fix_c64),
        .fix_reu      (fix_reu),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .verify_err   (verify_err),
        .cur_c64_addr (cur_c64_addr),
        .cur_reu_addr (cur_reu_addr),
        .cur_len      (cur_len)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // C64 bus manager: serves a request when dma_req differs from dma_ack and
    // answers by copying the current dma_req level.
    logic [7:0]  c64_mem [0:65535];
    logic        ack_r = 1'b0;
    logic [7:0]  q_r = 8'h00;
    bit          dma_busy = 0;
    int          dma_cnt = 0, dma_lat = 2, dma_starts = 0;
    logic [15:0] lat_a;
    logic        lat_rw;
    logic [7:0]  lat_d;
    assign bus.dma_ack = ack_r;
    assign bus.dma_q   = q_r;

    always @(negedge clk) begin
        if (dma_busy) begin
            if (dma_cnt > 0) dma_cnt--;
            else begin
                if (lat_rw) c64_mem[lat_a] = lat_d;
                else q_r = c64_mem[lat_a];
                ack_r    = bus.dma_req;
                dma_busy = 0;
            end
        end else if (!rst && bus.dma_req != ack_r) begin
            dma_busy = 1;
            dma_cnt  = dma_lat;
            lat_a    = bus.dma_a;
            lat_rw   = bus.dma_rw;
            lat_d    = bus.dma_d;
            dma_starts++;
        end
    end

    // Expansion RAM: one-cycle ack pulse after ram_lat extra cycles.
    logic [7:0] ram_mem [int unsigned];
    logic       ram_ack_r = 1'b0;
    logic [7:0] ram_rdata_r = 8'h00;
    int         ram_cnt = 0, ram_lat = 1, ram_reqs = 0;
    assign bus.ram_ack   = ram_ack_r;
    assign bus.ram_rdata = ram_rdata_r;

    function automatic logic [7:0] ram_rd(input int unsigned a);
        return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
    endfunction

    always @(negedge clk) begin
        if (ram_ack_r) ram_ack_r = 1'b0;
        else if (!rst && bus.ram_req) begin
            if (ram_cnt < ram_lat) ram_cnt++;
            else begin
                ram_cnt = 0;
                ram_reqs++;
                if (bus.ram_we) ram_mem[int'(bus.ram_addr)] = bus.ram_wdata;
                else ram_rdata_r = ram_rd(int'(bus.ram_addr));
                ram_ack_r = 1'b1;
            end
        end
    end

    typedef struct packed {
        logic [15:0] c64;
        logic [23:0] reu;
        logic [15:0] len;
        logic        chk_len;
        logic        verr;
        logic [7:0]  nmem;
        logic [31:0] dmas;
        logic [31:0] rams;
    } exp_t;
    typedef struct packed {
        logic        is_ram;
        logic [23:0] addr;
        logic [7:0]  val;
    } mem_t;
    exp_t exp_q[$];
    mem_t mem_q[$];
    exp_t e_m;
    mem_t m_m;

    task automatic push_mem(input logic is_ram, input logic [23:0] a, input logic [7:0] v);
        mem_t m;
        m.is_ram = is_ram; m.addr = a; m.val = v;
        mem_q.push_back(m);
    endtask

    task automatic push_exp(input logic [15:0] c64, input logic [23:0] reu, input logic [15:0] len,
                            input logic chk_len, input logic verr, input int nmem,
                            input int ndma, input int nram);
        exp_t e;
        e.c64 = c64; e.reu = reu; e.len = len; e.chk_len = chk_len; e.verr = verr;
        e.nmem = 8'(nmem); e.dmas = 32'(dma_starts + ndma); e.rams = 32'(ram_reqs + nram);
        exp_q.push_back(e);
    endtask

    // Monitor: every done pulse retires one scoreboard entry.
    always @(posedge clk) begin
        #1;
        if (!rst && done) begin
            if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
            else begin
                e_m = exp_q.pop_front();
                check("busy_at_done", 32'(busy), 32'd0);
                check("cur_c64_addr", 32'(cur_c64_addr), 32'(e_m.c64));
                check("cur_reu_addr", 32'(cur_reu_addr), 32'(e_m.reu));
                if (e_m.chk_len) check("cur_len", 32'(cur_len), 32'(e_m.len));
                check("verify_err", 32'(verify_err), 32'(e_m.verr));
                check("dma_cycles", 32'(dma_starts), e_m.dmas);
                check("ram_requests", 32'(ram_reqs), e_m.rams);
                for (int i = 0; i < int'(e_m.nmem); i++) begin
                    m_m = mem_q.pop_front();
                    if (m_m.is_ram) check("ram_byte", 32'(ram_rd(int'(m_m.addr))), 32'(m_m.val));
                    else check("c64_byte", 32'(c64_mem[m_m.addr[15:0]]), 32'(m_m.val));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [15:0] a, input logic [23:0] r,
                         input logic [15:0] l, input logic fc, input logic fr);
        @(negedge clk);
        cmd = c; cmd_c64_addr = a; cmd_reu_addr = r; cmd_len = l; fix_c64 = fc; fix_reu = fr;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 4000);
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            @(posedge clk); #1;
            check({name, "_done_width"}, 32'(done), 32'd0);
        end
    endtask

    int base_d, base_r;

    initial begin
        for (int i = 0; i < 65536; i++) c64_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_verify_err", 32'(verify_err), 32'd0);
        check("rst_dma_req", 32'(bus.dma_req), 32'd0);
        check("rst_ram_req", 32'(bus.ram_req), 32'd0);
        check("rst_cur", {cur_c64_addr, cur_len}, 32'd0);
        check("rst_cur_reu", 32'(cur_reu_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // STASH 3 bytes, with a cmd_start pulse while busy that must be ignored.
        c64_mem[16'hC000] = 8'h11; c64_mem[16'hC001] = 8'h22; c64_mem[16'hC002] = 8'h33;
        push_mem(1, 24'h000100, 8'h11); push_mem(1, 24'h000101, 8'h22);
        push_mem(1, 24'h000102, 8'h33);
        push_exp(16'hC003, 24'h000103, 16'd1, 1, 0, 3, 3, 3);
        issue(2'd0, 16'hC000, 24'h000100, 16'd3, 0, 0);
        repeat (3) @(negedge clk);
        cmd = 2'd1; cmd_c64_addr = 16'h1234; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done("stash");

        // FETCH 4 bytes with the RAM address held.
        ram_mem[32'h10] = 8'hAA;
        for (int i = 0; i < 4; i++) push_mem(0, 24'h000400 + 24'(i), 8'hAA);
        push_exp(16'h0404, 24'h000010, 16'd1, 1, 0, 4, 4, 4);
        issue(2'd1, 16'h0400, 24'h000010, 16'd4, 0, 1);
        wait_done("fetch");

        // SWAP one byte.
        c64_mem[16'h2000] = 8'h5A; ram_mem[32'h20] = 8'hA5;
        push_mem(0, 24'h002000, 8'hA5); push_mem(1, 24'h000020, 8'h5A);
        push_exp(16'h2001, 24'h000021, 16'd1, 1, 0, 2, 2, 2);
        issue(2'd2, 16'h2000, 24'h000020, 16'd1, 0, 0);
        wait_done("swap");

        // VERIFY 8 bytes with a mismatch on the third byte.
        for (int i = 0; i < 8; i++) begin
            c64_mem[16'h3000 + 16'(i)] = 8'h10 + 8'(i);
            ram_mem[32'h300 + 32'(i)]  = 8'h10 + 8'(i);
        end
        ram_mem[32'h302] = 8'hEE;
        push_exp(16'h3003, 24'h000303, 16'd0, 0, 1, 0, 3, 3);
        issue(2'd3, 16'h3000, 24'h000300, 16'd8, 0, 0);
        wait_done("verify_err");

        // Matching VERIFY clears the sticky error.
        push_exp(16'h3002, 24'h000302, 16'd1, 1, 0, 0, 2, 2);
        issue(2'd3, 16'h3000, 24'h000300, 16'd2, 0, 0);
        wait_done("verify_ok");

        // RAM address wraps from the top of the 24-bit space.
        c64_mem[16'h5000] = 8'hC1; c64_mem[16'h5001] = 8'hC2;
        push_mem(1, 24'hFFFFFF, 8'hC1); push_mem(1, 24'h000000, 8'hC2);
        push_exp(16'h5002, 24'h000001, 16'd1, 1, 0, 2, 2, 2);
        issue(2'd0, 16'h5000, 24'hFFFFFF, 16'd2, 0, 0);
        wait_done("wrap");

        // Fixed C64 address.
        c64_mem[16'h6000] = 8'h77; c64_mem[16'h6001] = 8'h99;
        push_mem(1, 24'h000400, 8'h77); push_mem(1, 24'h000401, 8'h77);
        push_exp(16'h6000, 24'h000402, 16'd1, 1, 0, 2, 2, 2);
        issue(2'd0, 16'h6000, 24'h000400, 16'd2, 1, 0);
        wait_done("fix_c64");

        // Reset while a C64 read is still outstanding; the bus acks afterwards.
        dma_lat = 8;
        c64_mem[16'h7000] = 8'h3C;
        issue(2'd0, 16'h7000, 24'h000500, 16'd1, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base_d = dma_starts;
        base_r = ram_reqs;
        repeat (20) @(negedge clk);
        check("rst_mid_no_new_dma", 32'(dma_starts), 32'(base_d));
        check("rst_mid_no_ram", 32'(ram_reqs), 32'(base_r));
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_req_aligned", 32'(bus.dma_req), 32'(bus.dma_ack));
        check("rst_mid_ram_untouched", 32'(ram_rd(32'h500)), 32'd0);

        // The engine recovers for a normal transfer.
        dma_lat = 2;
        push_mem(1, 24'h000500, 8'h3C);
        push_exp(16'h7001, 24'h000501, 16'd1, 1, 0, 1, 1, 1);
        issue(2'd0, 16'h7000, 24'h000500, 16'd1, 0, 0);
        wait_done("recover");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
